// File: rtl/mem_responder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_responder_if : request/response channels of mem_responder     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_func3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_func3, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_func3, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_responder : unified RV32I memory with wait states and errors  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    mem_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              write_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        func3_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [31:0] mem [DEPTH];

    logic func_ok;
    logic misaligned;
    logic req_err;

    always_comb begin
        func_ok = 1'b0;
        if (bus.req_write) begin
            func_ok = (bus.req_func3 <= 3'b010);
        end else begin
            case (bus.req_func3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: func_ok = 1'b1;
                default:                                func_ok = 1'b0;
            endcase
        end
        misaligned = ((bus.req_func3[1:0] == 2'b01) && bus.req_addr[0]) ||
                     ((bus.req_func3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_err = !func_ok || misaligned;
    end

    // Upper address bits are dropped so accesses wrap modulo the depth.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];

    logic [31:0] word;
    logic [31:0] shifted;
    logic [31:0] load_data;

    assign word    = mem[addr_q[ADDR_W+1:2]];
    assign shifted = word >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (func3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'd0, shifted[7:0]};
            3'b101:  load_data = {16'd0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    logic [3:0]  be;
    logic [31:0] wdata_al;

    always_comb begin
        case (func3_q[1:0])
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = 4'b0011 << {addr_q[1], 1'b0};
            default: be = 4'b1111;
        endcase
        wdata_al = wdata_q << {addr_q[1:0], 3'b000};
    end

    // No reset on the array; the rst term keeps a store from landing on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_ACCESS) && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr_q[ADDR_W+1:2]][b*8 +: 8] <= wdata_al[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            func3_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr[ADDR_W+1:0];
                        wdata_q <= bus.req_wdata;
                        func3_q <= bus.req_func3;
                        if (req_err) begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end else if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (!write_q) begin
                        rdata_q <= load_data;
                    end
                    state <= ST_RESP;
                end
                default: begin
                    if (bus.resp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = (state == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_responder : scoreboard bench for two mem_responder configs |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // sel=0 targets the WAIT_CYCLES=2 instance, sel=1 the WAIT_CYCLES=0 one.
    logic        sel    = 1'b0;
    logic        valid  = 1'b0;
    logic        write  = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [2:0]  func3  = '0;
    logic        rready = 1'b0;

    mem_responder_if bus2 ();
    mem_responder_if bus0 ();

    assign bus2.req_valid  = valid & ~sel;
    assign bus2.req_write  = write;
    assign bus2.req_addr   = addr;
    assign bus2.req_wdata  = wdata;
    assign bus2.req_func3  = func3;
    assign bus2.resp_ready = rready & ~sel;
    assign bus0.req_valid  = valid & sel;
    assign bus0.req_write  = write;
    assign bus0.req_addr   = addr;
    assign bus0.req_wdata  = wdata;
    assign bus0.req_func3  = func3;
    assign bus0.resp_ready = rready & sel;

    logic        rreq;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rerr;
    assign rreq   = sel ? bus0.req_ready  : bus2.req_ready;
    assign rvalid = sel ? bus0.resp_valid : bus2.resp_valid;
    assign rdata  = sel ? bus0.resp_rdata : bus2.resp_rdata;
    assign rerr   = sel ? bus0.resp_err   : bus2.resp_err;

    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mdl2 [1024];
    logic [31:0] mdl0 [1024];
    int total = 0;
    int bad   = 0;

    task automatic predict(input bit d, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3, output exp_t e);
        int          size;
        bit          legal;
        logic [9:0]  idx;
        logic [31:0] w;
        logic [31:0] s;
        idx = a[11:2];
        case (f3)
            3'b000, 3'b100: size = 1;
            3'b001, 3'b101: size = 2;
            default:        size = 4;
        endcase
        legal = wr ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w = d ? mdl0[idx] : mdl2[idx];
        e.rdata = 32'h0;
        e.err   = !legal || ((a % size) != 0);
        e.lat   = e.err ? 1 : (d ? 2 : 4);
        if (!e.err && wr) begin
            for (int b = 0; b < size; b++) w[(int'(a[1:0]) + b)*8 +: 8] = wd[b*8 +: 8];
            if (d) mdl0[idx] = w; else mdl2[idx] = w;
        end else if (!e.err) begin
            s = w >> (8 * int'(a[1:0]));
            case (f3)
                3'b000:  e.rdata = {{24{s[7]}}, s[7:0]};
                3'b001:  e.rdata = {{16{s[15]}}, s[15:0]};
                3'b100:  e.rdata = {24'h0, s[7:0]};
                3'b101:  e.rdata = {16'h0, s[15:0]};
                default: e.rdata = w;
            endcase
        end
    endtask

    task automatic xact(input bit d, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3, input int hold);
        exp_t e;
        exp_t got;
        int   lat;
        bit   seen;
        predict(d, wr, a, wd, f3, e);
        sb_q.push_back(e);
        sel = d; write = wr; addr = a; wdata = wd; func3 = f3; valid = 1'b1;
        rready = (hold == 0);
        total++;
        if (rreq !== 1'b1) begin bad++; $display("FAIL req_ready_idle a=%h got %b want 1", a, rreq); end
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        write = 1'($urandom); addr = $urandom; wdata = $urandom; func3 = 3'($urandom);
        total++;
        if (rreq !== 1'b0) begin bad++; $display("FAIL req_ready_busy a=%h got %b want 0", a, rreq); end
        lat = 1; seen = 0;
        while (!seen && lat <= 40) begin
            if (rvalid === 1'b1) seen = 1;
            else begin @(negedge clk); lat++; end
        end
        got = sb_q.pop_front();
        total++;
        if (!seen) begin
            bad++; $display("FAIL resp_timeout a=%h got none want lat %0d", a, got.lat);
            return;
        end
        if (lat != got.lat) begin bad++; $display("FAIL latency a=%h got %0d want %0d", a, lat, got.lat); end
        for (int i = 0; i < hold; i++) begin
            total++;
            if (rvalid !== 1'b1 || rdata !== got.rdata || rreq !== 1'b0) begin
                bad++;
                $display("FAIL hold_stable cyc=%0d got v=%b d=%h rr=%b want v=1 d=%h rr=0",
                         i, rvalid, rdata, rreq, got.rdata);
            end
            @(negedge clk);
        end
        rready = 1'b1;
        total++;
        if (rdata !== got.rdata) begin bad++; $display("FAIL rdata a=%h f3=%0d got %h want %h", a, f3, rdata, got.rdata); end
        total++;
        if (rerr !== got.err) begin bad++; $display("FAIL err a=%h f3=%0d got %b want %b", a, f3, rerr, got.err); end
        @(posedge clk);
        @(negedge clk);
        rready = 1'b0;
        total++;
        if (rvalid !== 1'b0 || rreq !== 1'b1 || rdata !== 32'h0 || rerr !== 1'b0) begin
            bad++;
            $display("FAIL after_handshake got v=%b rr=%b d=%h e=%b want 0 1 0 0", rvalid, rreq, rdata, rerr);
        end
    endtask

    task automatic test_reset();
        total++;
        if (bus2.req_ready !== 1'b1 || bus2.resp_valid !== 1'b0 ||
            bus2.resp_rdata !== 32'h0 || bus2.resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_w2 got rr=%b v=%b d=%h e=%b want 1 0 0 0",
                     bus2.req_ready, bus2.resp_valid, bus2.resp_rdata, bus2.resp_err);
        end
        total++;
        if (bus0.req_ready !== 1'b1 || bus0.resp_valid !== 1'b0 ||
            bus0.resp_rdata !== 32'h0 || bus0.resp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_w0 got rr=%b v=%b d=%h e=%b want 1 0 0 0",
                     bus0.req_ready, bus0.resp_valid, bus0.resp_rdata, bus0.resp_err);
        end
    endtask

    task automatic test_word();
        xact(0, 1, 32'h40, 32'hDEADBEEF, 3'b010, 0);
        xact(0, 0, 32'h40, 32'h0, 3'b010, 0);
    endtask

    task automatic test_bytes();
        xact(0, 1, 32'h43, 32'hAAAA_AA80, 3'b000, 0);
        xact(0, 0, 32'h43, 32'h0, 3'b000, 0);
        xact(0, 0, 32'h43, 32'h0, 3'b100, 0);
        xact(0, 0, 32'h40, 32'h0, 3'b010, 0);
        xact(0, 0, 32'h42, 32'h0, 3'b001, 0);
        xact(0, 0, 32'h42, 32'h0, 3'b101, 0);
        xact(0, 1, 32'h80, 32'h1122_3344, 3'b010, 0);
        xact(0, 1, 32'h82, 32'h5555_A5C3, 3'b001, 0);
        xact(0, 0, 32'h80, 32'h0, 3'b010, 0);
    endtask

    task automatic test_errors();
        xact(0, 0, 32'h42, 32'h0, 3'b010, 0);
        xact(0, 1, 32'h41, 32'hFFFF_FFFF, 3'b001, 0);
        xact(0, 1, 32'h40, 32'hFFFF_FFFF, 3'b011, 0);
        xact(0, 0, 32'h40, 32'h0, 3'b110, 0);
        xact(0, 0, 32'h40, 32'h0, 3'b010, 0);
    endtask

    task automatic test_backpressure();
        xact(0, 0, 32'h40, 32'h0, 3'b010, 5);
    endtask

    task automatic test_reset_mid(input int when);
        sel = 0; write = 1; addr = 32'h10; wdata = 32'h12345678; func3 = 3'b010;
        valid = 1; rready = 1;
        @(posedge clk);
        @(negedge clk);
        valid = 0;
        repeat (when - 1) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (rvalid !== 1'b0 || rreq !== 1'b1) begin
            bad++; $display("FAIL reset_mid_%0d got v=%b rr=%b want 0 1", when, rvalid, rreq);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rvalid !== 1'b0 || rreq !== 1'b1 || rdata !== 32'h0) begin
            bad++; $display("FAIL reset_mid_idle_%0d got v=%b rr=%b d=%h want 0 1 0", when, rvalid, rreq, rdata);
        end
        xact(0, 0, 32'h10, 32'h0, 3'b010, 0);
    endtask

    task automatic test_back_to_back();
        xact(1, 1, 32'h1004, 32'hCAFEF00D, 3'b010, 0);
        xact(1, 0, 32'h1004, 32'h0, 3'b010, 0);
        xact(1, 0, 32'h0004, 32'h0, 3'b010, 0);
        xact(1, 1, 32'h0006, 32'h0000_BEEF, 3'b001, 0);
        xact(1, 0, 32'h1004, 32'h0, 3'b010, 0);
        xact(1, 0, 32'h1007, 32'h0, 3'b000, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_word();
        test_bytes();
        test_errors();
        test_backpressure();
        xact(0, 1, 32'h10, 32'h0, 3'b010, 0);
        test_reset_mid(1);
        test_reset_mid(3);
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
